// File: rtl/minaret_pkg.sv
// Shared types and helpers for the minaret data-memory bridge.
package minaret_pkg;

    // Supported SRAM read latencies; the wait counter is sized for the maximum.
    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 4;
    localparam int unsigned CNT_W       = $clog2(LATENCY_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } dmem_state_t;

    // Expand a per-byte enable into a 32-bit bit mask (bit b -> byte lane b).
    function automatic logic [31:0] expand_mask(input logic [3:0] mask);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = {8{mask[b]}};
        end
        return res;
    endfunction

endpackage

// File: rtl/minaret_dmem_bridge.sv
// Bridge from the minaret core's dmem valid/ready port to a word-wide,
// byte-enabled synchronous SRAM with a fixed read latency. One request is
// handled at a time; bad requests are answered with a one-cycle error pulse.
module minaret_dmem_bridge
    import minaret_pkg::*;
#(
    parameter logic [31:0] BASE    = 32'h0001_0000,
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 1,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dmem_valid,
    output logic          dmem_ready,
    input  logic [31:0]   dmem_addr,
    input  logic [3:0]    dmem_wmask,
    input  logic [31:0]   dmem_wdata,
    input  logic [3:0]    dmem_rmask,
    output logic [31:0]   dmem_rdata,
    output logic          dmem_err,
    output logic          sram_en,
    output logic [3:0]    sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    dmem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       rmask_q, rmask_d;
    logic             dmem_ready_q, dmem_ready_d;
    logic [31:0]      dmem_rdata_q, dmem_rdata_d;
    logic             dmem_err_q, dmem_err_d;
    logic             sram_en_q, sram_en_d;
    logic [3:0]       sram_we_q, sram_we_d;
    logic [AW-1:0]    sram_addr_q, sram_addr_d;
    logic [31:0]      sram_wdata_q, sram_wdata_d;

    logic [31:0]      offset;
    logic             in_range;
    logic             req_err;
    logic             req_noop;

    // Request decode: the range check tests the offset's high bits instead of
    // comparing against BASE+4*DEPTH, so it cannot wrap at the top of memory.
    always_comb begin
        offset   = dmem_addr - BASE;
        in_range = (dmem_addr >= BASE) && ((offset >> (AW + 2)) == 32'd0);
        req_err  = (dmem_addr[1:0] != 2'b00) || !in_range
                   || ((dmem_wmask != 4'd0) && (dmem_rmask != 4'd0));
        req_noop = (dmem_wmask == 4'd0) && (dmem_rmask == 4'd0);
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        rmask_d      = rmask_q;
        dmem_ready_d = 1'b0;
        dmem_rdata_d = dmem_rdata_q;
        dmem_err_d   = 1'b0;
        sram_en_d    = 1'b0;
        sram_we_d    = 4'd0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (dmem_valid) begin
                    if (req_err || req_noop) begin
                        state_d      = RESP;
                        dmem_ready_d = 1'b1;
                        dmem_err_d   = req_err;
                        dmem_rdata_d = 32'd0;
                    end else begin
                        state_d      = ACCESS;
                        sram_en_d    = 1'b1;
                        sram_we_d    = dmem_wmask;
                        sram_addr_d  = offset[AW+1:2];
                        sram_wdata_d = dmem_wdata;
                        rmask_d      = dmem_rmask;
                    end
                end
            end
            ACCESS: begin
                if (rmask_q != 4'd0) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end else begin
                    state_d      = RESP;
                    dmem_ready_d = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    dmem_ready_d = 1'b1;
                    dmem_rdata_d = sram_rdata & expand_mask(rmask_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d      = IDLE;
                dmem_rdata_d = 32'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rmask_q      <= 4'd0;
            dmem_ready_q <= 1'b0;
            dmem_rdata_q <= 32'd0;
            dmem_err_q   <= 1'b0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 4'd0;
            sram_addr_q  <= '0;
            sram_wdata_q <= 32'd0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rmask_q      <= rmask_d;
            dmem_ready_q <= dmem_ready_d;
            dmem_rdata_q <= dmem_rdata_d;
            dmem_err_q   <= dmem_err_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign dmem_ready = dmem_ready_q;
    assign dmem_rdata = dmem_rdata_q;
    assign dmem_err   = dmem_err_q;
    assign sram_en    = sram_en_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_minaret_dmem_bridge.sv
// Bench for minaret_dmem_bridge: a behavioural SRAM, a table of single
// requests with hand-computed results, and directed multi-cycle sequences.

// Behavioural byte-enabled SRAM; read data appears LATENCY cycles after en.
// Cycles without a read carry a marker value so mistimed captures show up.
module minaret_sram_model #(
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 1,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem  [DEPTH];
    logic [31:0] pipe [LATENCY];

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'd0;
        for (int i = 0; i < int'(LATENCY); i++) pipe[i] = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        pipe[0] <= (en && we == 4'd0) ? mem[addr] : 32'hDEAD_BEEF;
        for (int i = 1; i < int'(LATENCY); i++) pipe[i] <= pipe[i-1];
    end

    assign rdata = pipe[LATENCY-1];
endmodule

module tb_minaret_dmem_bridge;

    localparam logic [31:0] BASE    = 32'h0001_0000;
    localparam int unsigned DEPTH   = 4096;
    localparam int unsigned LATENCY = 3;
    localparam int unsigned AW      = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          dmem_valid = 1'b0;
    logic          dmem_ready;
    logic [31:0]   dmem_addr = 32'd0;
    logic [3:0]    dmem_wmask = 4'd0;
    logic [31:0]   dmem_wdata = 32'd0;
    logic [3:0]    dmem_rmask = 4'd0;
    logic [31:0]   dmem_rdata;
    logic          dmem_err;
    logic          sram_en;
    logic [3:0]    sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    minaret_dmem_bridge #(
        .BASE    (BASE),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dmem_valid (dmem_valid),
        .dmem_ready (dmem_ready),
        .dmem_addr  (dmem_addr),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rmask (dmem_rmask),
        .dmem_rdata (dmem_rdata),
        .dmem_err   (dmem_err),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    minaret_sram_model #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (sram_addr),
        .wdata (sram_wdata),
        .rdata (sram_rdata)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [3:0]  rmask;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_en;
        logic [11:0] exp_saddr;
        logic [3:0]  exp_we;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input string name, input logic [31:0] addr,
                                input logic [3:0] wmask, input logic [31:0] wdata,
                                input logic [3:0] rmask, input int exp_cyc,
                                input logic exp_err, input logic [31:0] exp_rdata,
                                input int exp_en, input logic [11:0] exp_saddr,
                                input logic [3:0] exp_we);
        vec_t v;
        v.name = name;       v.addr = addr;           v.wmask = wmask;
        v.wdata = wdata;     v.rmask = rmask;         v.exp_cyc = exp_cyc;
        v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_en = exp_en;
        v.exp_saddr = exp_saddr; v.exp_we = exp_we;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue one request from an IDLE cycle; cycle k is the cycle after the
    // k-th rising edge, the sampling edge being edge 1 (end of cycle 0).
    task automatic run_req(input logic [31:0] addr, input logic [3:0] wmask,
                           input logic [31:0] wdata, input logic [3:0] rmask,
                           output logic seen, output int cyc, output logic err,
                           output logic [31:0] rdata, output int en_cnt,
                           output int en_cyc, output logic [11:0] saddr,
                           output logic [3:0] we);
        seen = 1'b0; cyc = 0; err = 1'b0; rdata = 32'd0;
        en_cnt = 0; en_cyc = 0; saddr = '0; we = 4'd0;
        @(negedge clk);
        dmem_valid = 1'b1;
        dmem_addr  = addr;
        dmem_wmask = wmask;
        dmem_wdata = wdata;
        dmem_rmask = rmask;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (sram_en) begin
                en_cnt++;
                en_cyc = k;
                saddr  = sram_addr;
                we     = sram_we;
            end
            if (dmem_ready) begin
                seen  = 1'b1;
                cyc   = k;
                err   = dmem_err;
                rdata = dmem_rdata;
                dmem_valid = 1'b0;
            end
        end
        dmem_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " dmem_ready"}, 32'(dmem_ready), 32'd0);
        check({tag, " dmem_err"},   32'(dmem_err),   32'd0);
        check({tag, " dmem_rdata"}, dmem_rdata,      32'd0);
        check({tag, " sram_en"},    32'(sram_en),    32'd0);
        check({tag, " sram_we"},    32'(sram_we),    32'd0);
        check({tag, " sram_addr"},  32'(sram_addr),  32'd0);
        check({tag, " sram_wdata"}, sram_wdata,      32'd0);
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen, err;
        int          cyc, en_cnt, en_cyc;
        logic [31:0] rdata;
        logic [11:0] saddr;
        logic [3:0]  we;
        int          ready_n, b2b_en;
        int          ready_cyc [2];
        logic [31:0] ready_dat [2];

        //                name          addr          wm     wdata          rm     cyc err rdata         en saddr    we
        vecs[0]  = mk("st_w3_full",  32'h0001_000C, 4'hF, 32'hAABB_CCDD, 4'h0, 2, 0, 32'h0000_0000, 1, 12'h003, 4'hF);
        vecs[1]  = mk("st_w2_lo",    32'h0001_0008, 4'h3, 32'hAABB_CCDD, 4'h0, 2, 0, 32'h0000_0000, 1, 12'h002, 4'h3);
        vecs[2]  = mk("st_w2_hi",    32'h0001_0008, 4'hC, 32'hAABB_CCDD, 4'h0, 2, 0, 32'h0000_0000, 1, 12'h002, 4'hC);
        vecs[3]  = mk("ld_w2_b0",    32'h0001_0008, 4'h0, 32'h0000_0000, 4'h1, 5, 0, 32'h0000_00DD, 1, 12'h002, 4'h0);
        vecs[4]  = mk("ld_w3_full",  32'h0001_000C, 4'h0, 32'h0000_0000, 4'hF, 5, 0, 32'hAABB_CCDD, 1, 12'h003, 4'h0);
        vecs[5]  = mk("ld_w2_b31",   32'h0001_0008, 4'h0, 32'h0000_0000, 4'hA, 5, 0, 32'hAA00_CC00, 1, 12'h002, 4'h0);
        vecs[6]  = mk("misaligned",  32'h0001_0002, 4'h0, 32'h0000_0000, 4'hF, 1, 1, 32'h0000_0000, 0, 12'h000, 4'h0);
        vecs[7]  = mk("above_top",   32'h0001_4000, 4'h0, 32'h0000_0000, 4'hF, 1, 1, 32'h0000_0000, 0, 12'h000, 4'h0);
        vecs[8]  = mk("below_base",  32'h0000_FFFC, 4'hF, 32'h1234_5678, 4'h0, 1, 1, 32'h0000_0000, 0, 12'h000, 4'h0);
        vecs[9]  = mk("st_last",     32'h0001_3FFC, 4'h8, 32'h5A00_0000, 4'h0, 2, 0, 32'h0000_0000, 1, 12'hFFF, 4'h8);
        vecs[10] = mk("ld_last",     32'h0001_3FFC, 4'h0, 32'h0000_0000, 4'hF, 5, 0, 32'h5A00_0000, 1, 12'hFFF, 4'h0);
        vecs[11] = mk("noop",        32'h0001_0008, 4'h0, 32'h0000_0000, 4'h0, 1, 0, 32'h0000_0000, 0, 12'h000, 4'h0);
        vecs[12] = mk("both_masks",  32'h0001_0008, 4'h1, 32'h0000_0000, 4'h1, 1, 1, 32'h0000_0000, 0, 12'h000, 4'h0);

        // Reset state.
        #12;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);

        // Table-driven single requests.
        for (int i = 0; i < NVEC; i++) begin
            run_req(vecs[i].addr, vecs[i].wmask, vecs[i].wdata, vecs[i].rmask,
                    seen, cyc, err, rdata, en_cnt, en_cyc, saddr, we);
            check({vecs[i].name, " ready_seen"}, 32'(seen), 32'd1);
            check({vecs[i].name, " ready_cycle"}, 32'(cyc), 32'(vecs[i].exp_cyc));
            check({vecs[i].name, " err"}, 32'(err), 32'(vecs[i].exp_err));
            check({vecs[i].name, " rdata"}, rdata, vecs[i].exp_rdata);
            check({vecs[i].name, " en_pulses"}, 32'(en_cnt), 32'(vecs[i].exp_en));
            if (vecs[i].exp_en != 0) begin
                check({vecs[i].name, " en_cycle"}, 32'(en_cyc), 32'd1);
                check({vecs[i].name, " sram_addr"}, 32'(saddr), 32'(vecs[i].exp_saddr));
                check({vecs[i].name, " sram_we"}, 32'(we), 32'(vecs[i].exp_we));
            end
        end

        // valid held over two loads: second is sampled the cycle after the
        // first ready, so readies land in cycles 5 and 11.
        ready_n = 0;
        b2b_en  = 0;
        ready_cyc[0] = 0; ready_cyc[1] = 0;
        ready_dat[0] = 32'd0; ready_dat[1] = 32'd0;
        @(negedge clk);
        dmem_valid = 1'b1;
        dmem_addr  = 32'h0001_000C;
        dmem_wmask = 4'h0;
        dmem_wdata = 32'd0;
        dmem_rmask = 4'hF;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (sram_en) b2b_en++;
            if (dmem_ready && ready_n < 2) begin
                ready_cyc[ready_n] = k;
                ready_dat[ready_n] = dmem_rdata;
                ready_n++;
                if (ready_n == 2) dmem_valid = 1'b0;
            end
        end
        dmem_valid = 1'b0;
        check("b2b ready_count", 32'(ready_n), 32'd2);
        check("b2b en_pulses", 32'(b2b_en), 32'd2);
        check("b2b first_ready_cycle", 32'(ready_cyc[0]), 32'd5);
        check("b2b second_ready_cycle", 32'(ready_cyc[1]), 32'd11);
        check("b2b first_rdata", ready_dat[0], 32'hAABB_CCDD);
        check("b2b second_rdata", ready_dat[1], 32'hAABB_CCDD);

        // Reset during the WAIT phase of a load.
        @(negedge clk);
        dmem_valid = 1'b1;
        dmem_addr  = 32'h0001_000C;
        dmem_rmask = 4'hF;
        @(posedge clk);
        #1;
        check("rst_mid sram_en_cycle1", 32'(sram_en), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        dmem_valid = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold dmem_ready", 32'(dmem_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);

        run_req(32'h0001_0010, 4'hF, 32'h0102_0304, 4'h0,
                seen, cyc, err, rdata, en_cnt, en_cyc, saddr, we);
        check("post_rst_store ready_seen", 32'(seen), 32'd1);
        check("post_rst_store ready_cycle", 32'(cyc), 32'd2);
        check("post_rst_store err", 32'(err), 32'd0);
        check("post_rst_store en_pulses", 32'(en_cnt), 32'd1);
        check("post_rst_store sram_addr", 32'(saddr), 32'h004);

        run_req(32'h0001_0010, 4'h0, 32'd0, 4'hF,
                seen, cyc, err, rdata, en_cnt, en_cyc, saddr, we);
        check("post_rst_load ready_cycle", 32'(cyc), 32'd5);
        check("post_rst_load rdata", rdata, 32'h0102_0304);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
